bk_slot_ctrl: RTL and testbench
===============================

Name: bk_slot_ctrl

Overview:
Parametrised backup-RAM persistence controller between the core's dual-port save RAM (port B) and the hps_io SD sector interface.
- Moves an N-sector save image to or from one of M slots in the mounted save file.
- Formats the RAM with a fixed header.
- Tracks dirty state.
- Holds the core in reset while a load is in progress.
Sits in emu beside the backup RAM, replacing ad-hoc save/load logic.

Parameters:
SECT_W, 4, log2 sectors per slot (16 x 512 B = 8 KiB)
SLOT_W, 2, log2 slot count
BUF_AW, 8, sd_buff_addr width (16-bit words per sector)
FMT_WORDS, 4, header words written by format (<= 2**BUF_AW)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
downloading  in  1  ROM download active
img_mounted  in  1  mount strobe from hps_io
img_readonly  in  1  mounted image read-only
img_size_nz  in  1  mounted image size non-zero
load_req  in  1  level; rising edge starts a load
save_req  in  1  level; rising edge starts a save
format_req  in  1  level; rising edge starts a format
slot  in  SLOT_W  target slot, sampled at start
core_wr  in  1  core write strobe to backup RAM (sets dirty)
sd_ack  in  1  hps_io sector acknowledge
sd_buff_addr  in  BUF_AW  hps_io buffer word address
sd_buff_wr  in  1  hps_io buffer write strobe
sd_lba  out  32  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
ram_addr  out  SECT_W+BUF_AW  port-B word address
ram_we  out  1  port-B write enable
ram_fmt  out  1  1 = port-B data from fmt_data, 0 = from sd_buff_dout
fmt_data  out  16  format header word
bk_ena  out  1  save file usable
busy  out  1  operation in progress
loading  out  1  load in progress (OR into core reset)
dirty  out  1  RAM modified since last load/save/format
done  out  1  one-cycle pulse, operation complete
err  out  1  one-cycle pulse, request rejected

Behaviour:
- Reset state: all outputs 0, state IDLE, sector counter 0, request edge detectors primed with current inputs (no spurious start).
- bk_ena:
  - cleared on the rising edge of downloading;
  - set in any cycle with downloading & img_mounted & img_size_nz & ~img_readonly;
  - unaffected by reset.
- States: IDLE, FMT, REQ, ACK_HI, ACK_LO.
- IDLE, rising edges detected; priority format > load > save when simultaneous:
  - format -> FMT, idx=0. Allowed without bk_ena.
  - load/save with bk_ena=0 -> err pulse next cycle, remain IDLE.
  - load/save with bk_ena=1 -> latch slot, sector=0, dir, -> REQ.
- Edges occurring while busy are discarded, not queued.
- FMT, one word per cycle:
  - ram_addr = idx (zero-extended); ram_we=1; ram_fmt=1; fmt_data = FMT_TBL[idx].
  - After idx = FMT_WORDS-1: done pulse, dirty=0, -> IDLE.
  - Latency FMT_WORDS+1 cycles from edge to done.
- REQ:
  - sd_lba = {zeros, slot_l, sector}.
  - sd_rd = load, sd_wr = save, -> ACK_HI.
- ACK_HI: on sd_ack=1, drop sd_rd/sd_wr in the same cycle the ack is registered, -> ACK_LO.
- ACK_LO: on sd_ack=0:
  - if sector all-ones: done pulse, dirty=0, -> IDLE;
  - else sector+1 -> REQ.
- During transfer:
  - ram_addr = {sector, sd_buff_addr}; ram_fmt=0.
  - ram_we = sd_buff_wr & sd_ack & load_dir; save never writes RAM.
- busy = state != IDLE.
- loading = busy & load_dir.
- dirty:
  - set by core_wr in any cycle;
  - cleared at done;
  - core_wr in the same cycle as done wins (stays set).
- Reset mid-operation:
  - -> IDLE, sd_rd/sd_wr drop immediately;
  - a late sd_ack while IDLE is ignored;
  - dirty is cleared by reset.
- sd_lba holds its last value in IDLE.

Decomposition:
- Package bk_pkg holds:
  - state enum;
  - FMT_TBL constant: 16'h5548, 16'h4D42, 16'h8800, 16'h8010 (HUBM header);
  - helper function building the LBA from slot and sector.
- One sub-module, bk_edge (rising-edge detector with reset priming), instantiated three times.
- FSM stays in bk_slot_ctrl.

Test Plan:
- Format: pulse format_req, bk_ena=0 -> 4 cycles of ram_we with addr 0..3, data 5548/4D42/8800/8010, done at cycle 5, err never asserted.
- Load slot 2: mount RW image during download, load_req edge -> sd_lba 0x20..0x2F in order, sd_rd drops on each ack rise; ram_we only on sd_buff_wr, with ram_addr={sector,buff_addr}; loading high throughout; done after 16th ack fall; dirty=0.
- Save with image read-only -> err pulse, no sd_wr, busy stays 0.
- Simultaneous load_req and save_req edges -> load executes (sd_rd), save edge lost; a save edge raised mid-load is also ignored.
- Dirty: core_wr -> dirty=1; save slot 1 completes (LBA 0x10..0x1F, sd_wr only) -> dirty=0; core_wr on the done cycle -> dirty=1.
- Reset asserted in ACK_LO of sector 5 -> next cycle sd_rd=sd_wr=busy=0; trailing sd_ack ignored; a subsequent load restarts at sector 0.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types, format header and LBA helper for the backup-RAM slot controller.
package bk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FMT    = 3'd1,
    ST_REQ    = 3'd2,
    ST_ACK_HI = 3'd3,
    ST_ACK_LO = 3'd4
  } bk_state_e;

  // "HUBM" header laid down by a format; element 0 is the first RAM word.
  localparam logic [3:0][15:0] FMT_TBL = {16'h8010, 16'h8800, 16'h4D42, 16'h5548};
  localparam int unsigned FMT_TBL_LEN = 4;

  function automatic logic [15:0] fmt_word(input int unsigned idx);
    logic [1:0] sel;
    sel = idx[1:0];
    return (idx < FMT_TBL_LEN) ? FMT_TBL[sel] : 16'h0000;
  endfunction

  function automatic logic [31:0] make_lba(input logic [31:0] slot_v,
                                           input logic [31:0] sector_v,
                                           input int unsigned sect_w);
    return (slot_v << sect_w) | sector_v;
  endfunction

endpackage

// File: rtl/bk_edge.sv
// Rising-edge detector; history keeps tracking through reset so a level held
// across reset never looks like a fresh request.
module bk_edge (
  input  logic clk_sys,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge clk_sys) begin
    sig_d <= sig;
  end

  assign rise = sig & ~sig_d & ~reset;

endmodule

// File: rtl/bk_slot_ctrl.sv
// Backup-RAM persistence controller: moves a save image between port B of the
// backup RAM and one slot of the mounted save file, or formats the RAM.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for a format/load/save request edge
// ST_FMT    | writing header word fmt_idx into the RAM
// ST_REQ    | presenting LBA, raising sd_rd or sd_wr
// ST_ACK_HI | waiting for hps_io to acknowledge the sector
// ST_ACK_LO | sector streaming; waiting for the ack to fall
module bk_slot_ctrl
  import bk_pkg::*;
#(
  parameter int SECT_W    = 4,
  parameter int SLOT_W    = 2,
  parameter int BUF_AW    = 8,
  parameter int FMT_WORDS = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     downloading,
  input  logic                     img_mounted,
  input  logic                     img_readonly,
  input  logic                     img_size_nz,
  input  logic                     load_req,
  input  logic                     save_req,
  input  logic                     format_req,
  input  logic [SLOT_W-1:0]        slot,
  input  logic                     core_wr,
  input  logic                     sd_ack,
  input  logic [BUF_AW-1:0]        sd_buff_addr,
  input  logic                     sd_buff_wr,
  output logic [31:0]              sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  output logic [SECT_W+BUF_AW-1:0] ram_addr,
  output logic                     ram_we,
  output logic                     ram_fmt,
  output logic [15:0]              fmt_data,
  output logic                     bk_ena,
  output logic                     busy,
  output logic                     loading,
  output logic                     dirty,
  output logic                     done,
  output logic                     err
);

  localparam int AW = SECT_W + BUF_AW;
  localparam logic [BUF_AW-1:0] FMT_LAST = BUF_AW'(FMT_WORDS - 1);

  bk_state_e         state;
  logic [BUF_AW-1:0] fmt_idx;
  logic [SECT_W-1:0] sector;
  logic [SLOT_W-1:0] slot_l;
  logic              load_dir;
  logic              dl_d;
  logic              rise_load, rise_save, rise_fmt;
  logic              finish;

  bk_edge u_edge_load (.clk_sys(clk_sys), .reset(reset), .sig(load_req),   .rise(rise_load));
  bk_edge u_edge_save (.clk_sys(clk_sys), .reset(reset), .sig(save_req),   .rise(rise_save));
  bk_edge u_edge_fmt  (.clk_sys(clk_sys), .reset(reset), .sig(format_req), .rise(rise_fmt));

  // Save-file usability follows the mount, not the core reset.
  always_ff @(posedge clk_sys) begin
    dl_d <= downloading;
    if (downloading & ~dl_d) bk_ena <= 1'b0;
    if (downloading & img_mounted & img_size_nz & ~img_readonly) bk_ena <= 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      fmt_idx  <= '0;
      sector   <= '0;
      slot_l   <= '0;
      load_dir <= 1'b0;
      sd_lba   <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise_fmt) begin
            state    <= ST_FMT;
            fmt_idx  <= '0;
            load_dir <= 1'b0;
          end else if (rise_load | rise_save) begin
            if (!bk_ena) begin
              err <= 1'b1;
            end else begin
              slot_l   <= slot;
              sector   <= '0;
              load_dir <= rise_load;
              state    <= ST_REQ;
            end
          end
        end
        ST_FMT: begin
          if (fmt_idx == FMT_LAST) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            fmt_idx <= fmt_idx + 1'b1;
          end
        end
        ST_REQ: begin
          sd_lba <= make_lba(32'(slot_l), 32'(sector), SECT_W);
          sd_rd  <= load_dir;
          sd_wr  <= ~load_dir;
          state  <= ST_ACK_HI;
        end
        ST_ACK_HI: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_ACK_LO;
          end
        end
        ST_ACK_LO: begin
          if (!sd_ack) begin
            if (&sector) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              sector <= sector + 1'b1;
              state  <= ST_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign finish = ((state == ST_FMT) && (fmt_idx == FMT_LAST)) ||
                  ((state == ST_ACK_LO) && !sd_ack && (&sector));

  // A core write landing on the completing edge keeps the RAM marked dirty.
  always_ff @(posedge clk_sys) begin
    if (reset)        dirty <= 1'b0;
    else if (core_wr) dirty <= 1'b1;
    else if (finish)  dirty <= 1'b0;
  end

  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_fmt  = 1'b0;
    fmt_data = '0;
    case (state)
      ST_FMT: begin
        ram_addr = AW'(fmt_idx);
        ram_we   = 1'b1;
        ram_fmt  = 1'b1;
        fmt_data = fmt_word(32'(fmt_idx));
      end
      ST_REQ, ST_ACK_HI, ST_ACK_LO: begin
        ram_addr = {sector, sd_buff_addr};
        ram_we   = sd_buff_wr & sd_ack & load_dir;
      end
      default: ;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign loading = busy & load_dir;

endmodule

// File: tb/tb_bk_slot_ctrl.sv
// Bench for bk_slot_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the controller.
module tb_bk_slot_ctrl;

  localparam int SECT_W = 4, SLOT_W = 2, BUF_AW = 8, FMT_WORDS = 4;
  localparam int OP_NONE = 0, OP_FMT = 1, OP_LOAD = 2, OP_SAVE = 3;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic downloading = 0, img_mounted = 0, img_readonly = 0, img_size_nz = 0;
  logic load_req = 0, save_req = 0, format_req = 0, core_wr = 0;
  logic [SLOT_W-1:0] slot = '0;
  logic sd_ack = 0, sd_buff_wr = 0;
  logic [BUF_AW-1:0] sd_buff_addr = '0;

  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, ram_we, ram_fmt, bk_ena, busy, loading, dirty, done, err;
  logic [SECT_W+BUF_AW-1:0] ram_addr;
  logic [15:0] fmt_data;

  always #5 clk_sys = ~clk_sys;

  bk_slot_ctrl #(.SECT_W(SECT_W), .SLOT_W(SLOT_W), .BUF_AW(BUF_AW), .FMT_WORDS(FMT_WORDS)) dut (
    .clk_sys(clk_sys), .reset(reset), .downloading(downloading), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size_nz(img_size_nz), .load_req(load_req),
    .save_req(save_req), .format_req(format_req), .slot(slot), .core_wr(core_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_fmt(ram_fmt), .fmt_data(fmt_data), .bk_ena(bk_ena), .busy(busy), .loading(loading),
    .dirty(dirty), .done(done), .err(err)
  );

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: an operation in flight, its progress, and the sticky flags.
  int m_op = OP_NONE, m_idx = 0, m_sector = 0, m_slot = 0;
  bit m_start = 0, m_line = 0, m_await = 0;
  bit m_done = 0, m_err = 0, m_dirty = 0, m_bk = 0, m_bk_known = 0, m_pdl = 0;
  bit p_ld = 0, p_sv = 0, p_fm = 0;
  logic [31:0] m_lba = 0;
  logic [15:0] hdr [4];

  always @(posedge clk_sys) begin : model_p
    bit rl, rs, rf, fin;
    rl = load_req && !p_ld;
    rs = save_req && !p_sv;
    rf = format_req && !p_fm;
    p_ld = load_req; p_sv = save_req; p_fm = format_req;
    fin = 0; m_done = 0; m_err = 0;
    if (reset) begin
      m_op = OP_NONE; m_start = 0; m_line = 0; m_await = 0;
      m_sector = 0; m_idx = 0; m_slot = 0; m_lba = 0; m_dirty = 0;
    end else begin
      if (m_op == OP_NONE) begin
        if (rf) begin
          m_op = OP_FMT; m_idx = 0;
        end else if (rl || rs) begin
          if (!m_bk) m_err = 1;
          else begin
            m_op = rl ? OP_LOAD : OP_SAVE;
            m_slot = int'(slot); m_sector = 0; m_start = 1;
          end
        end
      end else if (m_op == OP_FMT) begin
        if (m_idx == FMT_WORDS - 1) fin = 1;
        else m_idx++;
      end else if (m_start) begin
        m_start = 0; m_lba = 32'(m_slot * 16 + m_sector); m_line = 1; m_await = 1;
      end else if (m_await) begin
        if (sd_ack) begin m_line = 0; m_await = 0; end
      end else if (!sd_ack) begin
        if (m_sector == 15) fin = 1;
        else begin m_sector++; m_start = 1; end
      end
      if (fin) begin m_done = 1; m_op = OP_NONE; end
      if (core_wr) m_dirty = 1;
      else if (fin) m_dirty = 0;
    end
    if (downloading && !m_pdl) begin m_bk = 0; m_bk_known = 1; end
    if (downloading && img_mounted && img_size_nz && !img_readonly) begin m_bk = 1; m_bk_known = 1; end
    m_pdl = downloading;
  end

  logic [31:0] e_addr, e_fdata;
  bit e_we, e_fmt, e_xfer;

  always begin
    @(negedge clk_sys);
    #2;
    if (cmp_en) begin
      e_xfer = (m_op == OP_LOAD) || (m_op == OP_SAVE);
      e_we = 0; e_fmt = 0; e_addr = 0; e_fdata = 0;
      if (m_op == OP_FMT) begin
        e_we = 1; e_fmt = 1; e_addr = 32'(m_idx); e_fdata = 32'(hdr[m_idx]);
      end else if (e_xfer) begin
        e_addr = 32'(m_sector * 256) + 32'(sd_buff_addr);
        e_we = sd_buff_wr && sd_ack && (m_op == OP_LOAD);
      end
      chk("busy", 32'(busy), 32'(m_op != OP_NONE));
      chk("loading", 32'(loading), 32'(m_op == OP_LOAD));
      chk("sd_rd", 32'(sd_rd), 32'(m_line && m_op == OP_LOAD));
      chk("sd_wr", 32'(sd_wr), 32'(m_line && m_op == OP_SAVE));
      chk("sd_lba", sd_lba, m_lba);
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_fmt", 32'(ram_fmt), 32'(e_fmt));
      chk("ram_addr", 32'(ram_addr), e_addr);
      chk("fmt_data", 32'(fmt_data), e_fdata);
      chk("dirty", 32'(dirty), 32'(m_dirty));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      if (m_bk_known) chk("bk_ena", 32'(bk_ena), 32'(m_bk));
    end
  end

  // hps_io stand-in: answers sector requests with random delays and buffer traffic.
  bit h_en = 0;
  int h_st = 0, h_cnt = 0;

  task automatic host_update();
    if (h_en) begin
      if (h_st == 0 && (sd_rd || sd_wr)) begin h_st = 1; h_cnt = int'($urandom_range(0, 3)); end
      if (h_st == 1) begin
        if (h_cnt == 0) begin h_st = 2; h_cnt = int'($urandom_range(1, 5)); sd_ack = 1; end
        else h_cnt--;
      end else if (h_st == 2) begin
        if (h_cnt == 0) begin sd_ack = 0; h_st = 0; end
        else h_cnt--;
      end
      sd_buff_wr = sd_ack && ($urandom_range(0, 1) == 1);
      sd_buff_addr = 8'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    host_update();
    #1;
  endtask

  task automatic mount(input bit ro);
    downloading = 1; tick();
    img_mounted = 1; img_size_nz = 1; img_readonly = ro; tick();
    img_mounted = 0; tick();
    downloading = 0; tick();
    chk("mount_bk_ena", 32'(bk_ena), 32'(!ro));
  endtask

  task automatic run_xfer(input logic [31:0] base, input bit is_load, input bit poke_save);
    int k;
    bit prev_line, line, got;
    k = 0; prev_line = 0; got = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      line = sd_rd || sd_wr;
      if (line && !prev_line) begin
        chk("xfer_lba", sd_lba, base + 32'(k));
        chk("xfer_dir", 32'({sd_rd, sd_wr}), is_load ? 32'd2 : 32'd1);
        k++;
      end
      prev_line = line;
      if (poke_save) begin
        if (k == 3) save_req = 0;
        if (k == 6) save_req = 1;
      end
      if (busy) chk("xfer_loading", 32'(loading), 32'(is_load));
      if (done) begin got = 1; break; end
    end
    chk("xfer_done", 32'(got), 32'd1);
    chk("xfer_sectors", 32'(k), 32'd16);
    chk("xfer_dirty_clr", 32'(dirty), 32'd0);
  endtask

  function automatic logic [15:0] hdr_lit(input int c);
    case (c)
      1: return 16'h5548;
      2: return 16'h4D42;
      3: return 16'h8800;
      default: return 16'h8010;
    endcase
  endfunction

  initial begin
    int k;
    bit prev_line, line, hit, a;
    hdr[0] = 16'h5548; hdr[1] = 16'h4D42; hdr[2] = 16'h8800; hdr[3] = 16'h8010;

    tick(); tick();
    downloading = 1; tick();
    downloading = 0; tick();
    cmp_en = 1; tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);
    chk("rst_bk_ena", 32'(bk_ena), 32'd0);
    reset = 0; tick();

    // Format without a usable save file.
    format_req = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        chk("fmt_we", 32'(ram_we), 32'd1);
        chk("fmt_addr", 32'(ram_addr), 32'(c - 1));
        chk("fmt_data_lit", 32'(fmt_data), 32'(hdr_lit(c)));
        chk("fmt_done_early", 32'(done), 32'd0);
      end else begin
        chk("fmt_done", 32'(done), 32'd1);
        chk("fmt_we_end", 32'(ram_we), 32'd0);
      end
      chk("fmt_err", 32'(err), 32'd0);
    end
    format_req = 0; tick();

    // Load slot 2 from a writable image.
    mount(0);
    h_en = 1;
    core_wr = 1; tick(); core_wr = 0;
    chk("pre_load_dirty", 32'(dirty), 32'd1);
    slot = 2; load_req = 1;
    run_xfer(32'h20, 1, 0);
    load_req = 0; tick();

    // Save rejected on a read-only image.
    mount(1);
    save_req = 1; tick();
    chk("ro_err", 32'(err), 32'd1);
    chk("ro_busy", 32'(busy), 32'd0);
    tick();
    chk("ro_err_pulse", 32'(err), 32'd0);
    chk("ro_sd_wr", 32'(sd_wr), 32'd0);
    save_req = 0; tick();

    // Simultaneous load/save edges: load wins, later save edge discarded.
    mount(0);
    slot = 0; load_req = 1; save_req = 1;
    run_xfer(32'h00, 1, 1);
    load_req = 0; save_req = 0; tick(); tick();
    chk("sim_idle", 32'(busy), 32'd0);

    // Dirty tracking around a save of slot 1.
    core_wr = 1; tick(); core_wr = 0;
    chk("dirty_set", 32'(dirty), 32'd1);
    slot = 1; save_req = 1;
    run_xfer(32'h10, 0, 0);
    core_wr = 1; tick(); core_wr = 0;
    chk("dirty_done_win", 32'(dirty), 32'd1);
    save_req = 0; tick();

    // Reset in ACK_LO of sector 5, trailing ack, restart from sector 0.
    slot = 3; load_req = 1;
    k = 0; prev_line = 0; hit = 0;
    for (int i = 0; i < 2000; i++) begin
      a = sd_ack;
      tick();
      line = sd_rd || sd_wr;
      if (line && !prev_line) k++;
      prev_line = line;
      if (a && !sd_ack && k == 6) begin reset = 1; hit = 1; break; end
    end
    chk("rst_reached", 32'(hit), 32'd1);
    h_en = 0; tick();
    chk("rst_sd_rd", 32'(sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_dirty", 32'(dirty), 32'd0);
    reset = 0; sd_ack = 1; tick(); tick();
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_rd", 32'(sd_rd), 32'd0);
    sd_ack = 0; tick();
    load_req = 0; tick();
    h_st = 0; h_en = 1; load_req = 1;
    run_xfer(32'h30, 1, 0);
    load_req = 0; tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      tick();
      core_wr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) load_req = ~load_req;
      if ($urandom_range(0, 39) == 0) save_req = ~save_req;
      if ($urandom_range(0, 79) == 0) format_req = ~format_req;
      slot = 2'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) downloading = ~downloading;
      img_mounted = downloading && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) img_readonly = ~img_readonly;
      img_size_nz = ($urandom_range(0, 7) != 0);
    end
    core_wr = 0; reset = 0; load_req = 0; save_req = 0; format_req = 0;
    downloading = 0; img_mounted = 0;
    for (int i = 0; i < 400; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
